// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Config fields are MAX_WIDTH wide; a divider instance uses only the low WIDTH bits.
package clkdiv_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] period;
        logic [MAX_WIDTH-1:0] high;
    } div_cfg_t;

    // A usable waveform needs at least one high and one low cycle.
    function automatic logic cfg_valid(input logic [MAX_WIDTH-1:0] period,
                                       input logic [MAX_WIDTH-1:0] high);
        return (period >= MAX_WIDTH'(2)) && (high >= MAX_WIDTH'(1)) && (high < period);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/shadow config, pending flag, clkdiv and tick.
// Tick logic exists only when CLKDIV_TICK_EN is defined; otherwise tick is tied low.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH        = 26,
    parameter int unsigned RESET_PERIOD = 50_000_000,
    parameter int unsigned RESET_HIGH   = 25_000_000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     resync,
    input  logic     wr,
    input  div_cfg_t wr_cfg,
    output logic     pending,
    output logic     clkdiv,
    output logic     tick
);

    localparam div_cfg_t RESET_CFG = {MAX_WIDTH'(RESET_PERIOD), MAX_WIDTH'(RESET_HIGH)};

    logic             running;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    div_cfg_t         active;
    div_cfg_t         shadow;
    logic             wrap;
    logic             apply;

    assign cnt_inc = cnt + WIDTH'(1);
    assign wrap    = running && (MAX_WIDTH'(cnt) == active.period - MAX_WIDTH'(1));
    // Shadow moves to active only on a period boundary or while nothing is being generated.
    assign apply   = pending && (!running || (en && (resync || wrap)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            active  <= RESET_CFG;
            shadow  <= RESET_CFG;
            pending <= 1'b0;
            clkdiv  <= 1'b0;
        end else begin
            if (!en) begin
                running <= 1'b0;
                cnt     <= '0;
                clkdiv  <= 1'b0;
            end else if (!running || resync || wrap) begin
                running <= 1'b1;
                cnt     <= '0;
                clkdiv  <= 1'b1;
            end else begin
                cnt     <= cnt_inc;
                clkdiv  <= MAX_WIDTH'(cnt_inc) < active.high;
            end
            if (apply) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            // A write on a boundary edge lands after the old shadow was consumed.
            if (wr) begin
                shadow  <= wr_cfg;
                pending <= 1'b1;
            end
        end
    end

`ifdef CLKDIV_TICK_EN
    // Flags the last cycle of each period, aligned with clkdiv.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else if (!en || !running || resync || wrap) begin
            tick <= 1'b0;
        end else begin
            tick <= MAX_WIDTH'(cnt_inc) == active.period - MAX_WIDTH'(1);
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: config write decode/validation plus channel array.
// Optional end-of-period tick outputs are enabled with CLKDIV_TICK_EN.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter  int unsigned CHANNELS     = 4,
    parameter  int unsigned WIDTH        = 26,
    parameter  int unsigned RESET_PERIOD = 50_000_000,
    parameter  int unsigned RESET_HIGH   = 25_000_000,
    localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                resync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_high,
    output logic                cfg_ack,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] clkdiv,
    output logic [CHANNELS-1:0] tick
);

    // Parameter sanity, caught at elaboration.
    if (CHANNELS < 1) begin : g_bad_channels
        $error("clkdiv_multi: CHANNELS must be at least 1");
    end
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("clkdiv_multi: WIDTH out of range");
    end
    if (RESET_PERIOD < 2 || 64'(RESET_PERIOD) >= (64'd1 << WIDTH)) begin : g_bad_period
        $error("clkdiv_multi: RESET_PERIOD must satisfy 2 <= RESET_PERIOD < 2**WIDTH");
    end
    if (RESET_HIGH < 1 || RESET_HIGH >= RESET_PERIOD) begin : g_bad_high
        $error("clkdiv_multi: RESET_HIGH must satisfy 1 <= RESET_HIGH < RESET_PERIOD");
    end

    div_cfg_t wr_cfg;
    logic     ch_ok;
    logic     wr_ok;

    assign wr_cfg = {MAX_WIDTH'(cfg_period), MAX_WIDTH'(cfg_high)};
    assign ch_ok  = 32'(cfg_ch) < 32'(CHANNELS);
    assign wr_ok  = cfg_we && ch_ok && cfg_valid(wr_cfg.period, wr_cfg.high);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= wr_ok;
            cfg_err <= cfg_we && !wr_ok;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clkdiv_chan #(
            .WIDTH        (WIDTH),
            .RESET_PERIOD (RESET_PERIOD),
            .RESET_HIGH   (RESET_HIGH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .resync  (resync),
            .wr      (wr_ok && (cfg_ch == CH_W'(i))),
            .wr_cfg  (wr_cfg),
            .pending (pending[i]),
            .clkdiv  (clkdiv[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi (3 channels, 8-bit, reset period 10 / high 4).
// Tick expectations follow CLKDIV_TICK_EN; without it tick must stay 0.
module tb_clkdiv_multi;

    typedef struct {
        logic [2:0] en;
        logic       we;
        logic [1:0] ch;
        logic [7:0] period;
        logic [7:0] high;
        logic       resync;
        logic [2:0] exp_clk;
        logic [2:0] exp_pend;
        logic       exp_ack;
        logic       exp_err;
        logic [2:0] exp_tick;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic       resync;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic       cfg_ack;
    logic       cfg_err;
    logic [2:0] pending;
    logic [2:0] clkdiv;
    logic [2:0] tick;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[22];

    always #5 clk = ~clk;

    clkdiv_multi #(
        .CHANNELS     (3),
        .WIDTH        (8),
        .RESET_PERIOD (10),
        .RESET_HIGH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .resync     (resync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .pending    (pending),
        .clkdiv     (clkdiv),
        .tick       (tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] tick_exp(input logic [2:0] t);
`ifdef CLKDIV_TICK_EN
        return t;
`else
        return 3'b000 & t;
`endif
    endfunction

    task automatic wr(input logic [1:0] ch, input logic [7:0] p, input logic [7:0] h);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        cfg_high   = h;
    endtask

    // One clock, then compare the main outputs and drop one-shot inputs.
    task automatic step(input string tag, input logic [2:0] e_clk, input logic [2:0] e_pend,
                        input logic e_ack);
        @(posedge clk);
        #1;
        chk({tag, " clkdiv"},  32'(clkdiv),  32'(e_clk));
        chk({tag, " pending"}, 32'(pending), 32'(e_pend));
        chk({tag, " cfg_ack"}, 32'(cfg_ack), 32'(e_ack));
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'(0));
        cfg_we = 1'b0;
        resync = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " clkdiv"},  32'(clkdiv),  32'(0));
        chk({tag, " pending"}, 32'(pending), 32'(0));
        chk({tag, " cfg_ack"}, 32'(cfg_ack), 32'(0));
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'(0));
        chk({tag, " tick"},    32'(tick),    32'(0));
    endtask

    initial begin
        // en, we, ch, period, high, resync, exp_clk, exp_pend, exp_ack, exp_err, exp_tick
        vecs[0]  = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[3]  = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[4]  = '{3'b111, 1'b1, 2'd1, 8'd4, 8'd1, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, 3'b000};
        vecs[5]  = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 3'b000};
        vecs[6]  = '{3'b111, 1'b1, 2'd0, 8'd3, 8'd3, 1'b0, 3'b000, 3'b010, 1'b0, 1'b1, 3'b000};
        vecs[7]  = '{3'b111, 1'b1, 2'd2, 8'd1, 8'd1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b1, 3'b000};
        vecs[8]  = '{3'b111, 1'b1, 2'd3, 8'd6, 8'd2, 1'b0, 3'b000, 3'b010, 1'b0, 1'b1, 3'b000};
        vecs[9]  = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 3'b111};
        vecs[10] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[11] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[12] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[13] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 3'b010};
        vecs[14] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[15] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[16] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[17] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b010};
        vecs[18] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[19] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b101};
        vecs[20] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[21] = '{3'b111, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 3'b010};

        rst        = 1'b1;
        en         = 3'b000;
        resync     = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = 2'd0;
        cfg_period = 8'd0;
        cfg_high   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("after_reset");

        // Reset waveform, ch1 reconfig at cnt=3, invalid writes.
        for (int i = 0; i < 22; i++) begin
            en         = vecs[i].en;
            cfg_we     = vecs[i].we;
            cfg_ch     = vecs[i].ch;
            cfg_period = vecs[i].period;
            cfg_high   = vecs[i].high;
            resync     = vecs[i].resync;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d clkdiv", i),  32'(clkdiv),  32'(vecs[i].exp_clk));
            chk($sformatf("row%0d pending", i), 32'(pending), 32'(vecs[i].exp_pend));
            chk($sformatf("row%0d cfg_ack", i), 32'(cfg_ack), 32'(vecs[i].exp_ack));
            chk($sformatf("row%0d cfg_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
            chk($sformatf("row%0d tick", i),    32'(tick),    32'(tick_exp(vecs[i].exp_tick)));
        end
        cfg_we = 1'b0;
        resync = 1'b0;

        // Stop ch2, stage a ch0 config, then resync applies it with all running channels in phase.
        en = 3'b011;
        step("stop_ch2", 3'b011, 3'b000, 1'b0);
        step("pre_rs_a", 3'b001, 3'b000, 1'b0);
        wr(2'd0, 8'd6, 8'd3);
        step("pre_rs_w", 3'b000, 3'b001, 1'b1);
        resync = 1'b1;
        step("resync",   3'b011, 3'b000, 1'b0);
        step("rs_p1",    3'b001, 3'b000, 1'b0);
        step("rs_p2",    3'b001, 3'b000, 1'b0);
        step("rs_p3",    3'b000, 3'b000, 1'b0);
        step("rs_p4",    3'b010, 3'b000, 1'b0);
        step("rs_p5",    3'b000, 3'b000, 1'b0);
        step("rs_p6",    3'b001, 3'b000, 1'b0);

        // Drop en[0] mid-high, re-raise, then async reset between edges.
        en = 3'b010;
        step("en0_drop", 3'b000, 3'b000, 1'b0);
        en = 3'b011;
        step("en0_rise", 3'b011, 3'b000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 3'b000;
        @(posedge clk);
        #1;
        chk_all_zero("rst_release");

        // Write on ch2's wrap edge while a prior config is pending.
        en = 3'b100;
        step("w6_e1", 3'b100, 3'b000, 1'b0);
        step("w6_e2", 3'b100, 3'b000, 1'b0);
        wr(2'd2, 8'd5, 8'd2);
        step("w6_e3", 3'b100, 3'b100, 1'b1);
        step("w6_e4", 3'b100, 3'b100, 1'b0);
        for (int k = 5; k <= 10; k++) begin
            step($sformatf("w6_e%0d", k), 3'b000, 3'b100, 1'b0);
        end
        wr(2'd2, 8'd3, 8'd1);
        step("w6_wrap", 3'b100, 3'b100, 1'b1);
        step("w6_e12",  3'b100, 3'b100, 1'b0);
        step("w6_e13",  3'b000, 3'b100, 1'b0);
        step("w6_e14",  3'b000, 3'b100, 1'b0);
        step("w6_e15",  3'b000, 3'b100, 1'b0);
        chk("w6_e15 tick", 32'(tick), 32'(tick_exp(3'b100)));
        step("w6_e16",  3'b100, 3'b000, 1'b0);
        step("w6_e17",  3'b000, 3'b000, 1'b0);
        step("w6_e18",  3'b000, 3'b000, 1'b0);
        step("w6_e19",  3'b100, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
